// File: rtl/io_pkg.sv
// Shared constants for the IO input controller: FSM state encoding and the
// default debounce length.
package io_pkg;

  // 10 ms of stable samples at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // 3-bit state encoding; codes 6 and 7 are unreachable and recover to IDLE.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_PRESS = 3'd1;
  localparam logic [2:0] ST_DEB_PRESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE    = 3'd3;
  localparam logic [2:0] ST_WAIT_REL   = 3'd4;
  localparam logic [2:0] ST_DEB_REL    = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WAIT_PRESS = ST_WAIT_PRESS,
    DEB_PRESS  = ST_DEB_PRESS,
    CAPTURE    = ST_CAPTURE,
    WAIT_REL   = ST_WAIT_REL,
    DEB_REL    = ST_DEB_REL
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs, with a
// configurable reset value so idle levels are correct out of reset.
module sync2 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// IO input controller: while the CPU stalls on an IN instruction, waits for
// a debounced press of the active-low Enter button, captures the slide
// switches once, then requires a debounced release before re-arming.
//
// Output protocol: data_valid is a one-cycle strobe with no ready/backpressure;
// Input_Data is valid in the strobe cycle and holds until the next capture.
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [9:0]  sw,
  input  logic        Enter,
  input  logic        Input,
  output logic [31:0] Input_Data,
  output logic        data_valid,
  output logic        waiting,
  output logic [2:0]  state_dbg
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       sw_s;
  logic             enter_s;

  sync2 #(.WIDTH(10), .RESET_VALUE(10'b0)) u_sw_sync (
    .clk   (CLK),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // Button idles released (high) so reset never looks like a press.
  sync2 #(.WIDTH(1), .RESET_VALUE(1'b1)) u_enter_sync (
    .clk   (CLK),
    .reset (reset),
    .d     (Enter),
    .q     (enter_s)
  );

  // Press/capture/release sequencing, debounce counter and capture register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      Input_Data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Input) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!enter_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end else if (!Input) begin
            state <= IDLE;
          end
        end
        DEB_PRESS: begin
          if (!Input) begin
            state <= IDLE;
          end else if (enter_s) begin
            state <= WAIT_PRESS;
          end else if (cnt == CNT_LAST) begin
            state      <= CAPTURE;
            Input_Data <= {22'b0, sw_s};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          state <= WAIT_REL;
        end
        // The CPU request is deliberately ignored until the button is released.
        WAIT_REL: begin
          if (enter_s) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (!enter_s) begin
            state <= WAIT_REL;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state register only, so no input reaches them combinationally.
  assign data_valid = (state == CAPTURE);
  assign waiting    = (state == WAIT_PRESS) || (state == DEB_PRESS);
  assign state_dbg  = state;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl with a short debounce length. A phase-based
// reference model tracks runs of stable synchronized button samples.
module tb_io_input_ctrl;
  import io_pkg::*;

  localparam int N = 4;

  // Reference model phases.
  localparam int M_IDLE    = 0;  // not serving a CPU request
  localparam int M_ARMED   = 1;  // counting a stable press
  localparam int M_STROBE  = 2;  // strobe cycle
  localparam int M_RELEASE = 3;  // counting a stable release

  // ---------------- clock / reset ----------------
  logic        CLK;
  logic        reset;
  logic [9:0]  sw;
  logic        Enter;
  logic        Input;
  logic [31:0] Input_Data;
  logic        data_valid;
  logic        waiting;
  logic [2:0]  state_dbg;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  io_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .sw         (sw),
    .Enter      (Enter),
    .Input      (Input),
    .Input_Data (Input_Data),
    .data_valid (data_valid),
    .waiting    (waiting),
    .state_dbg  (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  logic mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_mode, n_mode;
  int         m_run, n_run;
  logic [31:0] m_data, n_data;
  logic       m_en1, m_en2, n_en1, n_en2;
  logic [9:0] m_sw1, m_sw2, n_sw1, n_sw2;
  logic       n_cap;
  logic [31:0] exp_q[$];

  always_comb begin
    n_mode = m_mode;
    n_run  = m_run;
    n_data = m_data;
    n_cap  = 1'b0;
    n_en1  = Enter;
    n_en2  = m_en1;
    n_sw1  = sw;
    n_sw2  = m_sw1;
    if (reset) begin
      n_mode = M_IDLE;
      n_run  = 0;
      n_data = '0;
      n_en1  = 1'b1;
      n_en2  = 1'b1;
      n_sw1  = '0;
      n_sw2  = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (Input) begin
            n_mode = M_ARMED;
            n_run  = 0;
          end
        end
        M_ARMED: begin
          if (m_run == 0) begin
            if (!m_en2) n_run = 1;
            else if (!Input) n_mode = M_IDLE;
          end else if (!Input) begin
            n_mode = M_IDLE;
            n_run  = 0;
          end else if (m_en2) begin
            n_run = 0;
          end else if (m_run == N) begin
            n_mode = M_STROBE;
            n_data = {22'b0, m_sw2};
            n_cap  = 1'b1;
          end else begin
            n_run = m_run + 1;
          end
        end
        M_STROBE: begin
          n_mode = M_RELEASE;
          n_run  = 0;
        end
        default: begin
          if (m_run == 0) begin
            if (m_en2) n_run = 1;
          end else if (!m_en2) begin
            n_run = 0;
          end else if (m_run == N) begin
            n_mode = M_IDLE;
            n_run  = 0;
          end else begin
            n_run = m_run + 1;
          end
        end
      endcase
    end
  end

  always @(posedge CLK) begin
    m_mode <= n_mode;
    m_run  <= n_run;
    m_data <= n_data;
    m_en1  <= n_en1;
    m_en2  <= n_en2;
    m_sw1  <= n_sw1;
    m_sw2  <= n_sw2;
    if (reset) exp_q.delete();
    if (n_cap) exp_q.push_back(n_data);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (mon_en) begin
      check_eq("model_valid",   {31'b0, data_valid}, {31'b0, (m_mode == M_STROBE)});
      check_eq("model_waiting", {31'b0, waiting},    {31'b0, (m_mode == M_ARMED)});
      check_eq("model_data",    Input_Data, m_data);
      if (data_valid) begin
        strobes++;
        if (exp_q.size() > 0) check_eq("scoreboard_data", Input_Data, exp_q.pop_front());
        else check_eq("unexpected_strobe", {31'b0, data_valid}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic release_and_idle();
    Enter = 1'b1;
    Input = 1'b0;
    step(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    reset = 1'b1;
    sw    = '0;
    Enter = 1'b1;
    Input = 1'b0;
    step(3);
    mon_en = 1'b1;
    check_eq("rst_data",    Input_Data, 32'd0);
    check_eq("rst_valid",   {31'b0, data_valid}, 32'd0);
    check_eq("rst_waiting", {31'b0, waiting}, 32'd0);
    check_eq("rst_state",   {29'b0, state_dbg}, {29'b0, ST_IDLE});
    reset = 1'b0;
    step(2);

    // Basic latency: strobe exactly after edge e6.
    Input = 1'b1;
    sw    = 10'h2A5;
    Enter = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_eq($sformatf("lat_valid_e%0d", k), {31'b0, data_valid}, {31'b0, (k == 6)});
      check_eq($sformatf("lat_waiting_e%0d", k), {31'b0, waiting}, {31'b0, (k <= 5)});
    end
    check_eq("lat_data", Input_Data, 32'h0000_02A5);
    release_and_idle();

    // Bounce: low 2, high 1, then low.
    s0 = strobes;
    sw = 10'h155;
    Input = 1'b1;
    Enter = 1'b0; step(2);
    Enter = 1'b1; step(1);
    Enter = 1'b0; step(20);
    check_eq("bounce_strobes", strobes - s0, 32'd1);
    check_eq("bounce_data", Input_Data, 32'h0000_0155);
    release_and_idle();

    // Long hold yields one strobe; release and re-press yields a second.
    s0 = strobes;
    sw = 10'h0F0;
    Input = 1'b1;
    Enter = 1'b0; step(50);
    check_eq("hold_strobes", strobes - s0, 32'd1);
    Enter = 1'b1; sw = 10'h3FF; step(15);
    Enter = 1'b0; step(20);
    check_eq("repress_strobes", strobes - s0, 32'd2);
    check_eq("repress_data", Input_Data, 32'h0000_03FF);
    release_and_idle();

    // CPU request withdrawn mid-debounce.
    s0 = strobes;
    sw = 10'h0AA;
    Input = 1'b1;
    Enter = 1'b0; step(4);
    Input = 1'b0; step(1);
    check_eq("abort_state", {29'b0, state_dbg}, {29'b0, ST_IDLE});
    check_eq("abort_data", Input_Data, 32'h0000_03FF);
    step(10);
    check_eq("abort_strobes", strobes - s0, 32'd0);
    Enter = 1'b1; step(5);

    // Reset in DEB_PRESS at cnt=2.
    sw = 10'h123;
    Input = 1'b1;
    Enter = 1'b0; step(5);
    check_eq("mid_state", {29'b0, state_dbg}, {29'b0, ST_DEB_PRESS});
    reset = 1'b1; Enter = 1'b1; step(1);
    check_eq("mid_rst_data", Input_Data, 32'd0);
    check_eq("mid_rst_valid", {31'b0, data_valid}, 32'd0);
    check_eq("mid_rst_waiting", {31'b0, waiting}, 32'd0);
    check_eq("mid_rst_state", {29'b0, state_dbg}, {29'b0, ST_IDLE});
    reset = 1'b0;
    s0 = strobes;
    step(10);
    check_eq("post_rst_strobes", strobes - s0, 32'd0);
    check_eq("post_rst_waiting", {31'b0, waiting}, 32'd1);
    Enter = 1'b0; step(10);
    check_eq("fresh_strobes", strobes - s0, 32'd1);
    check_eq("fresh_data", Input_Data, 32'h0000_0123);
    release_and_idle();

    // No CPU request: presses are ignored.
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      Enter = 1'b0; step($urandom_range(1, 8));
      check_eq("noreq_waiting", {31'b0, waiting}, 32'd0);
      Enter = 1'b1; step($urandom_range(1, 8));
    end
    check_eq("noreq_strobes", strobes - s0, 32'd0);

    // Randomized traffic against the model.
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      Input = ($urandom_range(0, 4) != 0);
      sw    = 10'($urandom_range(0, 1023));
      Enter = 1'($urandom_range(0, 1));
      step($urandom_range(1, 12));
    end
    release_and_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the stable-sample count N required to accept a press or release (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset; it SHALL be synchronous and active-high.
REQ-004 The block SHALL have port sw, input, 10, the raw asynchronous slide switches sw9..sw0.
REQ-005 The block SHALL have port Enter, input, 1, the raw asynchronous push button; it is active-low (0 = pressed).
REQ-006 The block SHALL have port Input, input, 1, the CPU input request; the CPU holds it high while stalled on an IN instruction.
REQ-007 The block SHALL have port Input_Data, output, 32, the captured switch value.
REQ-008 The block SHALL have port data_valid, output, 1, a one-cycle strobe marking that Input_Data is new.
REQ-009 The block SHALL have port waiting, output, 1, high while the block awaits a press (for an LED).

Function
REQ-010 sw and Enter SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The FSM SHALL have the states IDLE, WAIT_PRESS, DEB_PRESS, CAPTURE, WAIT_REL and DEB_REL.
REQ-012 IDLE: if Input=1, the FSM SHALL go to WAIT_PRESS; otherwise it SHALL stay in IDLE.
REQ-013 WAIT_PRESS: if the synchronized Enter is 0, the FSM SHALL go to DEB_PRESS and clear cnt to 0; if Input=0, it SHALL go to IDLE.
REQ-014 DEB_PRESS: if Input=0, the FSM SHALL go to IDLE. Otherwise, if Enter returns high, it SHALL go to WAIT_PRESS. Otherwise, if cnt=N-1, it SHALL go to CAPTURE. Otherwise it SHALL increment cnt.
REQ-015 On the transition into CAPTURE, Input_Data SHALL load {22'b0, synchronized sw}, zero-extended.
REQ-016 CAPTURE SHALL last exactly one cycle, with data_valid=1, and SHALL then go to WAIT_REL unconditionally.
REQ-017 WAIT_REL: if Enter is high, the FSM SHALL go to DEB_REL with cnt=0.
REQ-018 DEB_REL: if Enter falls low, the FSM SHALL return to WAIT_REL. At cnt=N-1, it SHALL go to IDLE. Otherwise it SHALL increment cnt. Input SHALL be ignored in WAIT_REL and DEB_REL.
REQ-019 Holding one press SHALL yield exactly one data_valid; a new capture SHALL require a debounced release and then a new press.
REQ-020 Latency: data_valid SHALL be high in the cycle after the (N+3)th rising edge that samples raw Enter low, provided Enter stays low and Input stays high throughout.
REQ-021 data_valid SHALL equal (state==CAPTURE), derived from the state register with no combinational path from inputs.
REQ-022 waiting SHALL be 1 in WAIT_PRESS and DEB_PRESS, and 0 in all other states.
REQ-023 Input_Data SHALL hold its value until the next capture; it SHALL NOT be cleared when Input falls.
REQ-024 cnt SHALL be $clog2(N) bits wide and SHALL never exceed N-1 (no wrap).
REQ-025 Any unreachable state encoding SHALL go to IDLE on the next edge.

Reset
REQ-026 While reset=1 at a rising edge: state=IDLE, cnt=0, Input_Data=0, data_valid=0, waiting=0, and synchronizer flops=sw 0 / Enter 1 (released).
REQ-027 Reset in any state, including mid-debounce or during CAPTURE, SHALL abort with no data_valid pulse; the first possible strobe SHALL follow a full new press sequence.

Structure
REQ-028 The state encoding (3-bit localparams) and the DEBOUNCE_CYCLES default SHALL live in the shared package io_pkg.
REQ-029 A single sub-module sync2 (parameterized width, reset value) SHALL implement the synchronizers and SHALL be instantiated twice.
REQ-030 The implementation SHALL contain no latches, no gated clocks, and no use of the button as a clock.

Verification (N=4)
REQ-031 Scenario: reset; Input=1; sw=10'h2A5; Enter low from edge e0. Required response: data_valid is 1 exactly in the cycle after edge e6; Input_Data=32'h000002A5; waiting=1 before the strobe and 0 after it.
REQ-032 Scenario: bounce with Enter low 2 cycles, high 1 cycle, then low. Required response: no strobe until 4 consecutive stable synchronized-low samples, then exactly one strobe.
REQ-033 Scenario: Enter held low 50 cycles, then released and re-pressed while Input=1. Required response: exactly 2 strobes; the second captures the new sw value 10'h3FF, giving Input_Data=32'h000003FF.
REQ-034 Scenario: Input drops to 0 during DEB_PRESS. Required response: state=IDLE, no strobe, and Input_Data keeps its old value.
REQ-035 Scenario: reset asserted for 1 cycle during DEB_PRESS at cnt=2. Required response: all outputs take their reset values and no strobe follows until a fresh press.
REQ-036 Scenario: Input=0 with Enter pressed repeatedly. Required response: waiting=0 and data_valid never asserts.
